// File: rtl/cache_direct_mapped.sv
// Direct-mapped, write-through, write-no-allocate word cache in front of a byte-wide SRAM port.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_direct_mapped #(
  parameter int AW     = 32,
  parameter int LINES  = 8,
  parameter int STAT_W = 16,
  localparam int IDXW  = $clog2(LINES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AW-1:0]     ADDR,
  input  logic [31:0]       DIN,
  input  logic              WE,
  input  logic              RREQ,
  output logic [31:0]       DOUT,
  output logic              RDY,
  output logic              BUSY,
  output logic [AW-1:0]     MADDR,
  output logic [7:0]        MDO,
  input  logic [7:0]        MDI,
  output logic              MREQ,
  output logic              MWE,
  input  logic              MRDY,
  output logic [STAT_W-1:0] HITS,
  output logic [STAT_W-1:0] MISSES
);

  localparam int TAGW = AW - 2 - IDXW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RHIT  = 3'd1,
    S_FILL  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_r, state_nx_s;
  logic [LINES-1:0]  valid_r;
  logic [TAGW-1:0]   tag_mem_r  [LINES];
  logic [31:0]       data_mem_r [LINES];

  logic [IDXW-1:0]   idx_s, lidx_s;
  logic [TAGW-1:0]   tag_s, ltag_s;
  logic              hit_s;
  logic              beat_done_s, last_done_s;
  logic [7:0]        wbyte_s;

  logic [AW-3:0]     waddr_r;
  logic [31:0]       din_r;
  logic [23:0]       fill_r;
  logic              wr_hit_r;
  logic [1:0]        beat_r;
  logic              mreq_r, mwe_r, rdy_r, busy_r;
  logic [AW-1:0]     maddr_r;
  logic [7:0]        mdo_r;
  logic [31:0]       dout_r;

  logic              unused_s;
  assign unused_s = ^ADDR[1:0];

  assign lidx_s      = waddr_r[IDXW-1:0];
  assign ltag_s      = waddr_r[AW-3:IDXW];
  assign beat_done_s = mreq_r & MRDY;
  assign last_done_s = beat_done_s & (beat_r == 2'd3);

  assign DOUT  = dout_r;
  assign RDY   = rdy_r;
  assign BUSY  = busy_r;
  assign MADDR = maddr_r;
  assign MDO   = mdo_r;
  assign MREQ  = mreq_r;
  assign MWE   = mwe_r;

  // Combinational lookup from the live CPU address
  always_comb begin
    idx_s = ADDR[IDXW+1:2];
    tag_s = ADDR[AW-1:IDXW+2];
    hit_s = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  end

  // Byte of the latched write data for the current beat
  always_comb begin
    wbyte_s = din_r[7:0];
    case (beat_r)
      2'd0:    wbyte_s = din_r[7:0];
      2'd1:    wbyte_s = din_r[15:8];
      2'd2:    wbyte_s = din_r[23:16];
      default: wbyte_s = din_r[31:24];
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (WE) begin
          state_nx_s = S_WRITE;
        end else if (RREQ) begin
          state_nx_s = hit_s ? S_RHIT : S_FILL;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RHIT:  state_nx_s = S_IDLE;
      S_FILL, S_WRITE: begin
        if (last_done_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register, memory-port sequencing and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= S_IDLE;
      valid_r  <= {LINES{1'b0}};
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
      mreq_r   <= 1'b0;
      mwe_r    <= 1'b0;
      maddr_r  <= {AW{1'b0}};
      mdo_r    <= 8'h00;
      dout_r   <= 32'h0000_0000;
      beat_r   <= 2'd0;
      waddr_r  <= {(AW-2){1'b0}};
      din_r    <= 32'h0000_0000;
      fill_r   <= 24'h00_0000;
      wr_hit_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != S_IDLE);
      rdy_r   <= (state_nx_s == S_RHIT) || (state_nx_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (WE) begin
            waddr_r  <= ADDR[AW-1:2];
            din_r    <= DIN;
            wr_hit_r <= hit_s;
            beat_r   <= 2'd0;
            mreq_r   <= 1'b1;
            mwe_r    <= 1'b1;
            maddr_r  <= {ADDR[AW-1:2], 2'b00};
            mdo_r    <= DIN[7:0];
          end else if (RREQ) begin
            waddr_r <= ADDR[AW-1:2];
            if (hit_s) begin
              dout_r <= data_mem_r[idx_s];
            end else begin
              beat_r  <= 2'd0;
              mreq_r  <= 1'b1;
              mwe_r   <= 1'b0;
              maddr_r <= {ADDR[AW-1:2], 2'b00};
            end
          end
        end
        S_FILL, S_WRITE: begin
          // A dropped MREQ gives the mandatory idle cycle between beats
          if (beat_done_s) begin
            mreq_r <= 1'b0;
            if (state_r == S_FILL) begin
              case (beat_r)
                2'd0:    fill_r[7:0]   <= MDI;
                2'd1:    fill_r[15:8]  <= MDI;
                2'd2:    fill_r[23:16] <= MDI;
                default: fill_r        <= fill_r;
              endcase
            end
            if (beat_r == 2'd3) begin
              if (state_r == S_FILL) begin
                valid_r[lidx_s] <= 1'b1;
                dout_r          <= {MDI, fill_r};
              end
            end else begin
              beat_r <= beat_r + 2'd1;
            end
          end else if (!mreq_r) begin
            mreq_r  <= 1'b1;
            maddr_r <= {waddr_r, beat_r};
            mdo_r   <= wbyte_s;
          end
        end
        S_DONE: begin
          mwe_r <= 1'b0;
        end
        default: begin
          mreq_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays; contents are meaningless while the valid bit is clear
  always_ff @(posedge CLK) begin
    if ((state_r == S_FILL) && last_done_s) begin
      tag_mem_r[lidx_s]  <= ltag_s;
      data_mem_r[lidx_s] <= {MDI, fill_r};
    end else if ((state_r == S_WRITE) && last_done_s && wr_hit_r) begin
      data_mem_r[lidx_s] <= din_r;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hits_r, misses_r;

  // Saturating hit and read-miss counters, counted at request acceptance
  always_ff @(posedge CLK) begin
    if (RST) begin
      hits_r   <= {STAT_W{1'b0}};
      misses_r <= {STAT_W{1'b0}};
    end else if (state_r == S_IDLE) begin
      if ((WE || RREQ) && hit_s && (hits_r != {STAT_W{1'b1}})) begin
        hits_r <= hits_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (!WE && RREQ && !hit_s && (misses_r != {STAT_W{1'b1}})) begin
        misses_r <= misses_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign HITS   = hits_r;
  assign MISSES = misses_r;
`else
  assign HITS   = {STAT_W{1'b0}};
  assign MISSES = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cache_direct_mapped.sv
// Scoreboard bench for cache_direct_mapped: an SRAM model checks memory beats, a monitor checks RDY/DOUT.
module tb_cache_direct_mapped;

  localparam int LAT = 2;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK, RST, WE, RREQ, RDY, BUSY, MREQ, MWE, MRDY;
  logic [31:0] ADDR, DIN, DOUT, MADDR;
  logic [7:0]  MDO, MDI;
  logic [15:0] HITS, MISSES;

  logic [7:0]  mem [256];
  logic [40:0] exp_beat_q [$];
  logic [31:0] exp_rsp_q [$];
  int          checks, failures, beats_seen, lat, eh, em;

  cache_direct_mapped dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RREQ(RREQ),
    .DOUT(DOUT), .RDY(RDY), .BUSY(BUSY), .MADDR(MADDR), .MDO(MDO), .MDI(MDI),
    .MREQ(MREQ), .MWE(MWE), .MRDY(MRDY), .HITS(HITS), .MISSES(MISSES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: answers each beat LAT+1 negedges after MREQ rises and checks it against the scoreboard
  initial begin
    logic [40:0] e;
    MRDY = 1'b0; MDI = 8'h00; lat = 0;
    forever begin
      @(negedge CLK);
      if (MRDY) begin
        MRDY = 1'b0;
      end else if (MREQ) begin
        if (lat >= LAT) begin
          lat = 0;
          MRDY = 1'b1;
          beats_seen++;
          if (MWE) mem[MADDR[7:0]] = MDO;
          else     MDI = mem[MADDR[7:0]];
          if (exp_beat_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat: got addr %0h we %0b expected no beat", MADDR, MWE);
          end else begin
            e = exp_beat_q.pop_front();
            chk("beat_we_addr", {31'd0, MWE, MADDR}, {31'd0, e[40:8]});
            if (MWE) chk("beat_mdo", {56'd0, MDO}, {56'd0, e[7:0]});
          end
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (RDY) begin
        if (exp_rsp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rdy: got RDY with DOUT %0h expected none", DOUT);
        end else begin
          chk("dout", {32'd0, DOUT}, {32'd0, exp_rsp_q.pop_front()});
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] din, input int exp_lat);
    int n;
    @(negedge CLK);
    ADDR = addr; DIN = din; WE = we; RREQ = re;
    @(posedge CLK); #1;
    WE = 1'b0; RREQ = 1'b0; ADDR = 32'hFFFF_FFFF; DIN = 32'h0;
    n = 0;
    do begin
      @(negedge CLK); n++;
    end while (!RDY && n < 400);
    chk("rdy_seen", {63'd0, RDY}, 64'd1);
    chk("busy_in_rdy", {63'd0, BUSY}, 64'd1);
    if (exp_lat > 0) begin
      chk("hit_latency", n, exp_lat);
      chk("hit_no_mreq", {63'd0, MREQ}, 64'd0);
    end
    @(negedge CLK);
    chk("rdy_one_pulse", {63'd0, RDY}, 64'd0);
    chk("busy_after", {63'd0, BUSY}, 64'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic miss);
    logic [31:0] a;
    if (miss) begin
      for (int k = 0; k < 4; k++) begin
        a = addr + 32'(k);
        exp_beat_q.push_back({1'b0, a, 8'h00});
      end
    end
    exp_rsp_q.push_back(exp);
    do_req(1'b0, 1'b1, addr, 32'h0, miss ? 0 : 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] din, input logic both,
                    input logic [31:0] held);
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      a = addr + 32'(k);
      exp_beat_q.push_back({1'b1, a, din[8*k +: 8]});
    end
    exp_rsp_q.push_back(held);
    do_req(1'b1, both, addr, din, 0);
  endtask

  task automatic stats(input string tag);
    chk({tag, "_hits"}, {48'd0, HITS}, STATS ? 64'(eh) : 64'd0);
    chk({tag, "_misses"}, {48'd0, MISSES}, STATS ? 64'(em) : 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    checks = 0; failures = 0; beats_seen = 0; eh = 0; em = 0;
    WE = 1'b0; RREQ = 1'b0; ADDR = 32'h0; DIN = 32'h0; RST = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h30] = 8'hA1; mem[8'h31] = 8'hB2; mem[8'h32] = 8'hC3; mem[8'h33] = 8'hD4;
    mem[8'h40] = 8'h55; mem[8'h41] = 8'h66; mem[8'h42] = 8'h77; mem[8'h43] = 8'h88;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdy",   {63'd0, RDY},  64'd0);
    chk("rst_busy",  {63'd0, BUSY}, 64'd0);
    chk("rst_mreq",  {63'd0, MREQ}, 64'd0);
    chk("rst_mwe",   {63'd0, MWE},  64'd0);
    chk("rst_dout",  {32'd0, DOUT}, 64'd0);
    chk("rst_maddr", {32'd0, MADDR}, 64'd0);
    chk("rst_mdo",   {56'd0, MDO},  64'd0);
    stats("rst");
    @(negedge CLK);
    RST = 1'b0;

    // 1: cold read miss
    rd(32'h10, 32'h4433_2211, 1'b1); em++; stats("t1");
    // 2: read hit
    rd(32'h10, 32'h4433_2211, 1'b0); eh++; stats("t2");
    // 3: write hit, DOUT holds the last read value
    wr(32'h10, 32'hDEAD_BEEF, 1'b0, 32'h4433_2211); eh++;
    rd(32'h10, 32'hDEAD_BEEF, 1'b0); eh++; stats("t3");
    // 4: conflict on index 4
    rd(32'h10, 32'hDEAD_BEEF, 1'b0); eh++;
    rd(32'h30, 32'hD4C3_B2A1, 1'b1); em++;
    rd(32'h10, 32'hDEAD_BEEF, 1'b1); em++; stats("t4");
    // 5: WE and RREQ together, write miss does not allocate
    wr(32'h20, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF);
    rd(32'h20, 32'h1234_5678, 1'b1); em++; stats("t5");

    // 6: reset during the third fill beat
    for (int k = 0; k < 4; k++) begin
      a = 32'h40 + 32'(k);
      exp_beat_q.push_back({1'b0, a, 8'h00});
    end
    beats_seen = 0;
    @(negedge CLK);
    ADDR = 32'h40; RREQ = 1'b1;
    @(posedge CLK); #1;
    RREQ = 1'b0;
    n = 0;
    while (!(beats_seen == 2 && MREQ) && n < 400) begin
      @(posedge CLK); #1; n++;
    end
    chk("t6_reached_beat2", {63'd0, (beats_seen == 2 && MREQ)}, 64'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("t6_mreq_low", {63'd0, MREQ}, 64'd0);
    chk("t6_busy_low", {63'd0, BUSY}, 64'd0);
    chk("t6_dout_clr", {32'd0, DOUT}, 64'd0);
    exp_beat_q.delete();
    exp_rsp_q.delete();
    eh = 0; em = 0;
    stats("t6_rst");
    @(negedge CLK);
    RST = 1'b0;
    rd(32'h40, 32'h8877_6655, 1'b1); em++;
    rd(32'h10, 32'hDEAD_BEEF, 1'b1); em++; stats("t6");

    repeat (4) @(negedge CLK);
    chk("beat_q_empty", exp_beat_q.size(), 64'd0);
    chk("rsp_q_empty", exp_rsp_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
